// File: rtl/digit_serial_adder_if.sv
// Handshake and operand/result bundle for digit_serial_adder.
// Ports (master = controller side):
//   start, sub, a, b, cin : request and operands, driven by the master
//   busy, done            : operation status, driven by the adder
//   sum, cout, ovf        : registered result, driven by the adder
interface digit_serial_adder_if #(
   parameter int unsigned N = 16
);
   logic         start;
   logic         sub;
   logic [N-1:0] a;
   logic [N-1:0] b;
   logic         cin;
   logic         busy;
   logic         done;
   logic [N-1:0] sum;
   logic         cout;
   logic         ovf;

   modport master (
      output start, sub, a, b, cin,
      input  busy, done, sum, cout, ovf
   );

   modport slave (
      input  start, sub, a, b, cin,
      output busy, done, sum, cout, ovf
   );
endinterface

// File: rtl/digit_serial_adder.sv
// Digit-serial adder/subtractor: adds one D-bit digit per cycle through a
// D-bit ripple slice, holding the carry in a register between digits, so an
// N-bit operation takes K = N/D RUN cycles.
// Ports:
//   clk  : system clock, rising edge
//   rst  : synchronous active-high reset
//   bus  : digit_serial_adder_if.slave (start/sub/a/b/cin in,
//          busy/done/sum/cout/ovf out, all outputs registered)
module digit_serial_adder #(
   parameter int unsigned N = 16,
   parameter int unsigned D = 4
) (
   input  logic                 clk,
   input  logic                 rst,
   digit_serial_adder_if.slave  bus
);

   localparam int unsigned K  = N / D;
   localparam int unsigned CW = (K > 1) ? $clog2(K) : 1;
   localparam int unsigned DW = D + 1;

   typedef enum logic {IDLE, RUN} state_t;

   state_t         state_q, state_d;
   logic [CW-1:0]  cnt_q,   cnt_d;
   logic           carry_q, carry_d;
   logic [N-1:0]   opa_q,   opa_d;
   logic [N-1:0]   opb_q,   opb_d;
   logic [N-1:0]   res_q,   res_d;
   logic [N-1:0]   sum_q,   sum_d;
   logic           cout_q,  cout_d;
   logic           ovf_q,   ovf_d;
   logic           busy_q,  busy_d;
   logic           done_q,  done_d;

   logic [D-1:0]   da, db, ds;
   logic           dc, c_msb, last;

   // Digit slice: select the current digit and ripple-add it with the held carry
   always_comb begin
      da   = '0;
      db   = '0;
      last = (cnt_q == CW'(K - 1));
      for (int k = 0; k < int'(K); k++) begin
         if (cnt_q == CW'(k)) begin
            da = opa_q[k*D +: D];
            db = opb_q[k*D +: D];
         end
      end
      {dc, ds} = {1'b0, da} + {1'b0, db} + DW'(carry_q);
      // Carry into the digit MSB recovered from its sum bit
      c_msb = ds[D-1] ^ da[D-1] ^ db[D-1];
   end

   // Next-state and output logic
   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      carry_d = carry_q;
      opa_d   = opa_q;
      opb_d   = opb_q;
      res_d   = res_q;
      sum_d   = sum_q;
      cout_d  = cout_q;
      ovf_d   = ovf_q;
      busy_d  = busy_q;
      done_d  = 1'b0;

      case (state_q)
         IDLE: begin
            if (bus.start) begin
               opa_d   = bus.a;
               // Subtraction as a + ~b + 1
               opb_d   = bus.sub ? ~bus.b : bus.b;
               carry_d = bus.sub ? 1'b1 : bus.cin;
               cnt_d   = '0;
               busy_d  = 1'b1;
               state_d = RUN;
            end
         end
         RUN: begin
            for (int k = 0; k < int'(K); k++) begin
               if (cnt_q == CW'(k)) res_d[k*D +: D] = ds;
            end
            carry_d = dc;
            cnt_d   = cnt_q + CW'(1);
            if (last) begin
               sum_d   = res_d;
               cout_d  = dc;
               ovf_d   = c_msb ^ dc;
               done_d  = 1'b1;
               busy_d  = 1'b0;
               state_d = IDLE;
            end
         end
         default: state_d = IDLE;
      endcase
   end

   // State and output registers
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q <= IDLE;
         cnt_q   <= '0;
         carry_q <= 1'b0;
         opa_q   <= '0;
         opb_q   <= '0;
         res_q   <= '0;
         sum_q   <= '0;
         cout_q  <= 1'b0;
         ovf_q   <= 1'b0;
         busy_q  <= 1'b0;
         done_q  <= 1'b0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         carry_q <= carry_d;
         opa_q   <= opa_d;
         opb_q   <= opb_d;
         res_q   <= res_d;
         sum_q   <= sum_d;
         cout_q  <= cout_d;
         ovf_q   <= ovf_d;
         busy_q  <= busy_d;
         done_q  <= done_d;
      end
   end

   assign bus.busy = busy_q;
   assign bus.done = done_q;
   assign bus.sum  = sum_q;
   assign bus.cout = cout_q;
   assign bus.ovf  = ovf_q;

endmodule

// File: doc/digit_serial_adder.md
# digit_serial_adder

Parametrised digit-serial adder/subtractor: the sequential successor to the combinational N-bit ripple-carry adder. Each cycle it adds one D-bit digit of the operands through a D-bit ripple slice. The carry is held in a register between digits, so an N-bit add or subtract completes in N/D cycles with D-bit combinational depth. It sits wherever wide arithmetic is needed but a full N-bit carry chain would limit clock frequency or area, and connects to a controller through a start/busy/done handshake.

## Interface
- N, 16: operand and result width in bits; must be a multiple of D.
- D, 4: digit width, i.e. bits added per cycle; 1 ≤ D ≤ N; K = N/D digit cycles per operation.
- clk  input  1  system clock, all state updates on rising edge.
- rst  input  1  synchronous, active-high reset.
- start  input  1  request a new operation; sampled only when busy = 0.
- sub  input  1  mode select: 0 = a + b + cin, 1 = a − b (cin ignored).
- a  input  N  operand A, sampled with start.
- b  input  N  operand B, sampled with start.
- cin  input  1  carry-in for add mode, sampled with start.
- busy  output  1  high while an operation is in progress.
- done  output  1  single-cycle pulse: result outputs updated this cycle.
- sum  output  N  result, held until the next done.
- cout  output  1  carry out of bit N−1; in sub mode, 1 = no borrow (a ≥ b unsigned).
- ovf  output  1  two's-complement overflow, equal to (carry into bit N−1) XOR (carry out of bit N−1).

## Operation
- States: IDLE, RUN.
- Reset (rst = 1 at an edge) forces state to IDLE and clears digit counter, carry register, busy, done, sum, cout and ovf to 0. Any operation in progress is aborted with no done pulse.
- IDLE: if start = 1, the block latches the following and moves to RUN with digit counter = 0, busy = 1:
  - a;
  - b, or ~b when sub = 1;
  - initial carry: cin when sub = 0, 1 when sub = 1.
- IDLE with start = 0: the block holds.
- RUN, each edge:
  - digit k = counter is added from operand bits [kD+D−1 : kD] plus the carry register;
  - the D-bit digit sum is written into bits [kD+D−1 : kD] of an internal result register;
  - the digit carry-out replaces the carry register;
  - the counter increments.
- On the edge that processes digit K−1:
  - sum ← the full internal result, with the final digit included;
  - cout ← the digit carry-out;
  - ovf ← the carry into bit N−1 XOR the carry out of bit N−1;
  - done ← 1, busy ← 0, state ← IDLE.
- done is high for exactly one cycle and then returns to 0.
- start while busy = 1 is ignored. Operands and mode changing during RUN have no effect.
- sum, cout and ovf change only on the final-digit edge or on reset. They hold their previous values throughout RUN.
- Arithmetic is modulo 2^N with no saturation.
- The D = N configuration (K = 1) is legal: one RUN cycle.

## Timing
- Start accepted at edge E0. Digits are processed at edges E1..EK. done = 1 and the new sum, cout and ovf are visible in the cycle after EK.
- Latency is therefore K edges from start acceptance to done.
- busy rises in the cycle after E0 and falls in the same cycle that done rises.
- Back-to-back operation: start = 1 during the done cycle is accepted (state is IDLE). Throughput is one result per K+1 cycles.
- Reset asserted during RUN takes effect at the same edge; start is ignored on any edge where rst = 1.
- No combinational path from inputs to outputs; all outputs are registered.

## Test plan
- N=16, D=4, add, a=0xFFFF, b=0x0001, cin=0 -> after 4 edges: done pulse, sum=0x0000, cout=1, ovf=0; busy high for exactly 4 cycles.
- Add, a=0x7FFF, b=0x0001, cin=0 -> sum=0x8000, cout=0, ovf=1. Then add a=0x1234, b=0x0F0F, cin=1 -> sum=0x2144, cout=0, ovf=0.
- Sub checks, each with the full required result:
  - a=0x0005, b=0x0007 -> sum=0xFFFE, cout=0, ovf=0;
  - a=0x8000, b=0x0001 -> sum=0x7FFF, cout=1, ovf=1.
- Handshake and hold behaviour:
  - start held high with changing operands during RUN: the first result is unaffected;
  - new start asserted in the done cycle: second result 4 edges later;
  - sum holds its old value throughout the second RUN.
- Reset mid-operation: assert rst at the second RUN edge -> busy=0, done never pulses, sum=0, cout=0, ovf=0; the next start completes normally.
- Parameter sweep (N=16 with D∈{1,4,16}; N=12 with D=3): 1000 random vectors in both modes, compared against a + b + cin and a − b, including the cout/ovf rules; latency must equal N/D in every run.
